// File: rtl/prog_ctr.sv
// Program counter and IDLE/RUN/HALT run-control sequencer for the 9-bit-ISA core.
// Drives the instruction ROM address and keeps a saturating cycle count per run.
module prog_ctr #(
  parameter int PW = 10,
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [PW-1:0] StartAddr,
  input  logic          BranchUp,
  input  logic          BranchDown,
  input  logic [W-1:0]  PCTarget,
  input  logic          Ack,
  output logic [PW-1:0] PC,
  output logic          Running,
  output logic          Done,
  output logic          BranchErr,
  output logic [CW-1:0] CycleCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state_q;
  logic [PW-1:0] pc_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic [PW-1:0] tgt_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) return v;
    return v + CW'(1);
  endfunction

  // Branch distance is an unsigned offset; the size cast zero-extends it.
  assign tgt_d = PW'(PCTarget);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (Start) begin
      state_q <= RUN;
      pc_q    <= StartAddr;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          cnt_q <= sat_inc(cnt_q);
          if (Ack) begin
            state_q <= HALT;
          end else if (BranchUp && BranchDown) begin
            err_q <= 1'b1;
            pc_q  <= pc_q + PW'(1);
          end else if (BranchUp) begin
            pc_q <= pc_q - tgt_d;
          end else if (BranchDown) begin
            pc_q <= pc_q + tgt_d;
          end else begin
            pc_q <= pc_q + PW'(1);
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PC         = pc_q;
  assign Running    = (state_q == RUN);
  assign Done       = (state_q == HALT);
  assign BranchErr  = err_q;
  assign CycleCount = cnt_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Directed bench for prog_ctr: sequencing, branches, wrap, conflict, halt, reset and saturation.
module tb_prog_ctr;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [9:0]  StartAddr;
  logic        BranchUp;
  logic        BranchDown;
  logic [7:0]  PCTarget;
  logic        Ack;
  logic [9:0]  PC, PC4;
  logic        Running, Running4;
  logic        Done, Done4;
  logic        BranchErr, BranchErr4;
  logic [15:0] CycleCount;
  logic [3:0]  CycleCount4;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  prog_ctr #(.PW(10), .W(8), .CW(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .BranchUp(BranchUp), .BranchDown(BranchDown), .PCTarget(PCTarget), .Ack(Ack),
    .PC(PC), .Running(Running), .Done(Done), .BranchErr(BranchErr),
    .CycleCount(CycleCount)
  );

  prog_ctr #(.PW(10), .W(8), .CW(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .BranchUp(BranchUp), .BranchDown(BranchDown), .PCTarget(PCTarget), .Ack(Ack),
    .PC(PC4), .Running(Running4), .Done(Done4), .BranchErr(BranchErr4),
    .CycleCount(CycleCount4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_at(input logic [9:0] a);
    StartAddr = a;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; StartAddr = '0;
    BranchUp = 1'b0; BranchDown = 1'b0; PCTarget = '0; Ack = 1'b0;
    tick(); tick();
    chk("rst_pc", PC, 0);
    chk("rst_running", Running, 0);
    chk("rst_done", Done, 0);
    chk("rst_err", BranchErr, 0);
    chk("rst_cnt", CycleCount, 0);
    Reset = 1'b0;

    // Decoder glitches in IDLE are ignored
    BranchDown = 1'b1; PCTarget = 8'h07; Ack = 1'b1;
    tick(); tick();
    chk("idle_pc", PC, 0);
    chk("idle_running", Running, 0);
    chk("idle_done", Done, 0);
    BranchDown = 1'b0; Ack = 1'b0; PCTarget = '0;

    // Sequential run from 0x010
    start_at(10'h010);
    chk("start_pc", PC, 10'h010);
    chk("start_running", Running, 1);
    chk("start_cnt", CycleCount, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("seq_pc%0d", i), PC, 10'h010 + i);
    end
    chk("seq_running", Running, 1);
    chk("seq_done", Done, 0);
    chk("seq_cnt", CycleCount, 5);

    // Forward then backward branch, then zero-distance self-loop
    start_at(10'h020);
    BranchDown = 1'b1; PCTarget = 8'h05;
    tick();
    chk("bdown_pc", PC, 10'h025);
    BranchDown = 1'b0; BranchUp = 1'b1; PCTarget = 8'h0A;
    tick();
    chk("bup_pc", PC, 10'h01B);
    BranchUp = 1'b0; BranchDown = 1'b1; PCTarget = 8'h00;
    tick();
    chk("selfloop_pc", PC, 10'h01B);
    BranchDown = 1'b0;
    // Large target exercises zero-extension (no sign extension of 0xF0)
    BranchDown = 1'b1; PCTarget = 8'hF0;
    tick();
    chk("zext_pc", PC, 10'h10B);
    BranchDown = 1'b0; PCTarget = '0;

    // Modulo-2^PW wrap in both directions
    start_at(10'h001);
    BranchUp = 1'b1; PCTarget = 8'h03;
    tick();
    chk("wrap_down_pc", PC, 10'h3FE);
    BranchUp = 1'b0; PCTarget = '0;
    tick();
    chk("wrap_3ff", PC, 10'h3FF);
    tick();
    chk("wrap_up_pc", PC, 10'h000);

    // Conflicting branch, then halt with the error still flagged
    start_at(10'h040);
    BranchUp = 1'b1; BranchDown = 1'b1; PCTarget = 8'h10;
    tick();
    chk("conf_pc", PC, 10'h041);
    chk("conf_err", BranchErr, 1);
    BranchUp = 1'b0;
    Ack = 1'b1;
    tick();
    chk("conf_halt_pc", PC, 10'h041);
    chk("conf_halt_done", Done, 1);
    chk("conf_halt_err", BranchErr, 1);
    chk("conf_halt_cnt", CycleCount, 2);
    Ack = 1'b0; BranchDown = 1'b0;

    // Halt at 0x033 with a simultaneous forward branch
    start_at(10'h033);
    chk("restart_err", BranchErr, 0);
    chk("restart_done", Done, 0);
    Ack = 1'b1; BranchDown = 1'b1; PCTarget = 8'h05;
    tick();
    chk("halt_pc", PC, 10'h033);
    chk("halt_done", Done, 1);
    chk("halt_running", Running, 0);
    chk("halt_cnt", CycleCount, 1);
    Ack = 1'b0; BranchDown = 1'b0;
    BranchUp = 1'b1; tick();
    BranchUp = 1'b0; tick();
    BranchUp = 1'b1; tick();
    BranchUp = 1'b0;
    chk("halt_hold_pc", PC, 10'h033);
    chk("halt_hold_cnt", CycleCount, 1);
    chk("halt_hold_done", Done, 1);
    start_at(10'h000);
    chk("post_halt_pc", PC, 0);
    chk("post_halt_done", Done, 0);
    chk("post_halt_cnt", CycleCount, 0);
    chk("post_halt_running", Running, 1);

    // Level-sensitive Start reloads the entry address every edge
    StartAddr = 10'h100; Start = 1'b1;
    tick(); tick(); tick();
    chk("start_hold_pc", PC, 10'h100);
    chk("start_hold_cnt", CycleCount, 0);
    Start = 1'b0;
    tick();
    chk("start_drop_pc", PC, 10'h101);

    // Run to PC=0x155 with CycleCount=0x30, then async reset mid-cycle
    start_at(10'h125);
    for (int i = 0; i < 48; i++) tick();
    chk("pre_rst_pc", PC, 10'h155);
    chk("pre_rst_cnt", CycleCount, 16'h0030);
    chk("sat_cnt4", CycleCount4, 4'hF);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_pc", PC, 0);
    chk("async_running", Running, 0);
    chk("async_cnt", CycleCount, 0);
    chk("async_err", BranchErr, 0);
    chk("async_done", Done, 0);

    // Reset overrides a simultaneous Start
    StartAddr = 10'h2AA; Start = 1'b1;
    tick();
    chk("rst_start_pc", PC, 0);
    chk("rst_start_running", Running, 0);
    Start = 1'b0;
    Reset = 1'b0;

    // Saturation of the narrow counter over a 20-cycle run
    start_at(10'h000);
    for (int i = 0; i < 20; i++) tick();
    chk("sat4_cnt", CycleCount4, 4'hF);
    chk("sat16_cnt", CycleCount, 16'd20);
    chk("sat4_pc", PC4, 10'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
